stream_word_serializer: RTL

- Reader-side companion to the team's valid/ready FIFO.
- Pops one wide word from the FIFO output port and replays it as RATIO narrow beats on a downstream valid/ready stream, LSB slice first.
- Flags the final beat of each word with dataOutLast.
- Sustains one beat per cycle, with no bubble between consecutive words.

---
 rtl/stream_pkg.sv | 12 +
 rtl/stream_word_serializer.sv | 117 +++++++++++
 2 files changed

// File: rtl/stream_pkg.sv
// Shared types and default widths for the stream serializer and its FIFO bench.
package stream_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } serState_t;

  localparam int DATA_WIDTH = 32;
  localparam int BEAT_WIDTH = 8;

endpackage

// File: rtl/stream_word_serializer.sv
// Replays each wide FIFO word as RATIO narrow valid/ready beats, LSB slice first.
// Optional STREAM_WORD_SERIALIZER_STATS_EN adds wordCount/stallCount outputs.
module stream_word_serializer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = DATA_WIDTH,
  parameter int OUT_WIDTH = BEAT_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IN_WIDTH-1:0]  dataIn,
  input  logic                 dataInValid,
  output logic                 dataInReady,
  output logic [OUT_WIDTH-1:0] dataOut,
  output logic                 dataOutValid,
  input  logic                 dataOutReady,
  output logic                 dataOutLast
`ifdef STREAM_WORD_SERIALIZER_STATS_EN
  ,
  output logic [31:0]          wordCount,
  output logic [31:0]          stallCount
`endif
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("stream_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
  end

  serState_t            state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [IN_WIDTH-1:0]  shift_reg_q, shift_reg_d;
  logic                 in_xfer;
  logic                 out_xfer;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    shift_reg_d  = shift_reg_q;

    dataOutValid = (state_q == SHIFT);
    dataOutLast  = (state_q == SHIFT) && (beat_cnt_q == LAST_BEAT);
    dataOut      = shift_reg_q[OUT_WIDTH-1:0];
    dataInReady  = (state_q == EMPTY) || (dataOutLast && dataOutReady);

    in_xfer      = dataInValid && dataInReady;
    out_xfer     = dataOutValid && dataOutReady;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          shift_reg_d = dataIn;
          beat_cnt_d  = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (out_xfer) begin
          if (beat_cnt_q != LAST_BEAT) begin
            shift_reg_d = shift_reg_q >> OUT_WIDTH;
            beat_cnt_d  = beat_cnt_q + 1'b1;
          end else if (in_xfer) begin
            shift_reg_d = dataIn;
            beat_cnt_d  = '0;
          end else begin
            // Clear the register so dataOut idles at zero while empty.
            shift_reg_d = '0;
            beat_cnt_d  = '0;
            state_d     = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      beat_cnt_q  <= '0;
      shift_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      shift_reg_q <= shift_reg_d;
    end
  end

`ifdef STREAM_WORD_SERIALIZER_STATS_EN
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    word_count_d  = word_count_q;
    stall_count_d = stall_count_q;
    if (in_xfer) word_count_d = word_count_q + 32'd1;
    if (dataOutValid && !dataOutReady) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      word_count_q  <= word_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign wordCount  = word_count_q;
  assign stallCount = stall_count_q;
`endif

endmodule
